// File: rtl/seq_det_pkg.sv
// Shared types for the programmable sequence detector: FSM states and match modes.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_DONE
  } statetype;

  // The encoding 2'b11 is reserved and is treated as MODE_OVERLAP.
  typedef enum logic [1:0] {
    MODE_OVERLAP,
    MODE_NONOVERLAP,
    MODE_SINGLE
  } mode_t;

endpackage

// File: rtl/seq_window_cmp.sv
// Compares the sliding window (stored history plus the arriving symbol) against the loaded pattern.
module seq_window_cmp #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 3
) (
  input  logic [(DEPTH-1)*SYM_W-1:0] history,
  input  logic [SYM_W-1:0]           in_sym,
  input  logic [DEPTH*SYM_W-1:0]     pattern_q,
  output logic                       eq
);

  // Symbol 0 (oldest) sits in the LSBs on both sides, so a whole-vector compare is symbol-wise.
  assign eq = ({in_sym, history} == pattern_q);

endmodule

// File: rtl/seq_detector_param.sv
// Programmable DEPTH-symbol sequence detector with overlap / non-overlap / single-shot modes
// and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int DEPTH = 3,
  parameter int CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   cfg_load,
  input  logic [DEPTH*SYM_W-1:0] cfg_pattern,
  input  logic [1:0]             cfg_mode,
  input  logic                   in_valid,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic                   cnt_clr,
  output logic                   match,
  output logic [CNT_W-1:0]       match_count,
  output logic                   armed
);

  localparam int HIST_W = (DEPTH-1)*SYM_W;
  localparam int FILL_W = $clog2(DEPTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH-1);

  statetype               state, state_n;
  mode_t                  mode_q;
  logic [DEPTH*SYM_W-1:0] pattern_q;
  logic [DEPTH*SYM_W-1:0] window;
  logic [HIST_W-1:0]      history, history_n;
  logic [FILL_W-1:0]      fill, fill_n;
  logic [CNT_W-1:0]       count_q;
  logic                   eq;

  assign window = {in_sym, history};

  seq_window_cmp #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH)
  ) u_cmp (
    .history   (history),
    .in_sym    (in_sym),
    .pattern_q (pattern_q),
    .eq        (eq)
  );

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_n   = state;
    fill_n    = fill;
    history_n = history;
    match     = 1'b0;
    if (cfg_load) begin
      state_n = ST_HUNT;
      fill_n  = '0;
    end else if (state == ST_HUNT && in_valid) begin
      match     = (fill == FILL_MAX) && eq;
      history_n = window[DEPTH*SYM_W-1:SYM_W];
      if (fill != FILL_MAX) fill_n = fill + 1'b1;
      if (match) begin
        case (mode_q)
          MODE_NONOVERLAP: fill_n = '0;
          MODE_SINGLE: begin
            state_n = ST_DONE;
            fill_n  = '0;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      fill      <= '0;
      history   <= '0;
      pattern_q <= '0;
      mode_q    <= MODE_OVERLAP;
    end else begin
      state   <= state_n;
      fill    <= fill_n;
      history <= history_n;
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        mode_q    <= mode_t'(cfg_mode);
      end
    end
  end

  // cnt_clr beats a coincident match; cfg_load leaves the count alone.
  always_ff @(posedge CLK) begin
    if (reset) begin
      count_q <= '0;
    end else if (cnt_clr) begin
      count_q <= '0;
    end else if (match && count_q != {CNT_W{1'b1}}) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign match_count = count_q;
  assign armed       = (state == ST_HUNT);

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a queue-based reference model predicts each cycle's
// outputs; a negedge monitor pops and compares. Two DUTs share inputs (CNT_W=8 and CNT_W=2).
module tb_seq_detector_param;

  localparam int SYM_W = 2;
  localparam int DEPTH = 3;
  localparam int PW    = DEPTH*SYM_W;

  logic          CLK = 1'b0;
  logic          reset, cfg_load, in_valid, cnt_clr;
  logic [PW-1:0] cfg_pattern;
  logic [1:0]    cfg_mode;
  logic [SYM_W-1:0] in_sym;
  logic          match8, match2, armed8, armed2;
  logic [7:0]    count8;
  logic [1:0]    count2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic m;
    logic a;
    int   c8;
    int   c2;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  int   m_state;   // 0 idle, 1 hunting, 2 done
  int   m_win[$];  // last valid symbols since load, oldest first
  int   m_pat[DEPTH];
  int   m_mode;
  int   m_c8, m_c2;
  bit   m_known = 1'b0;

  always #5 CLK = ~CLK;

  seq_detector_param #(.SYM_W(SYM_W), .DEPTH(DEPTH), .CNT_W(8)) dut8 (
    .CLK(CLK), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_mode(cfg_mode), .in_valid(in_valid), .in_sym(in_sym), .cnt_clr(cnt_clr),
    .match(match8), .match_count(count8), .armed(armed8));

  seq_detector_param #(.SYM_W(SYM_W), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .CLK(CLK), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_mode(cfg_mode), .in_valid(in_valid), .in_sym(in_sym), .cnt_clr(cnt_clr),
    .match(match2), .match_count(count2), .armed(armed2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic step(input logic v, input int s, input logic ld = 1'b0, input int pat = 0,
                      input int md = 0, input logic clr = 1'b0, input logic rst = 1'b0);
    bit   hit;
    exp_t e;
    @(posedge CLK);
    #1;
    reset       = rst;
    cfg_load    = ld;
    cfg_pattern = PW'(pat);
    cfg_mode    = 2'(md);
    in_valid    = v;
    in_sym      = SYM_W'(s);
    cnt_clr     = clr;

    hit = 1'b0;
    if (!rst && !ld && m_state == 1 && v && m_win.size() == DEPTH-1) begin
      hit = 1'b1;
      for (int k = 0; k < DEPTH-1; k++) if (m_win[k] != m_pat[k]) hit = 1'b0;
      if (s != m_pat[DEPTH-1]) hit = 1'b0;
    end
    if (m_known) begin
      e.m = hit; e.a = (m_state == 1); e.c8 = m_c8; e.c2 = m_c2;
      exp_q.push_back(e);
    end

    if (rst) begin
      m_state = 0; m_win.delete(); m_mode = 0; m_c8 = 0; m_c2 = 0;
      for (int k = 0; k < DEPTH; k++) m_pat[k] = 0;
      m_known = 1'b1;
    end else begin
      if (clr) begin
        m_c8 = 0; m_c2 = 0;
      end else if (hit) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
      if (ld) begin
        for (int k = 0; k < DEPTH; k++) m_pat[k] = (pat >> (k*SYM_W)) & ((1 << SYM_W) - 1);
        m_mode = md; m_win.delete(); m_state = 1;
      end else if (m_state == 1 && v) begin
        m_win.push_back(s);
        if (m_win.size() > DEPTH-1) void'(m_win.pop_front());
        if (hit) begin
          if (m_mode == 1) m_win.delete();
          else if (m_mode == 2) begin m_win.delete(); m_state = 2; end
        end
      end
    end
  endtask

  task automatic load(input int pat, input int md);
    step(1'b1, 3, 1'b1, pat, md);
  endtask

  // Monitor: every cycle with a prediction is compared on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("match8", 32'(match8), 32'(e.m));
      check("match2", 32'(match2), 32'(e.m));
      check("armed",  32'(armed8), 32'(e.a));
      check("armed2", 32'(armed2), 32'(e.a));
      check("count8", 32'(count8), e.c8);
      check("count2", 32'(count2), e.c2);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_mode = '0;
    in_valid = 1'b0; in_sym = '0; cnt_clr = 1'b0;
    step(0, 0, .rst(1)); step(0, 0, .rst(1));

    // 1: no pattern loaded -> ignored
    step(1, 1); step(1, 2); step(1, 3);

    // 2: 01,10,11 in overlap mode, then again with bubbles
    load(6'b11_10_01, 0);
    step(1, 1); step(1, 2); step(1, 3);
    step(1, 1); step(0, 0); step(0, 2); step(1, 2); step(0, 1); step(1, 3);

    // 3: six 01s in each mode
    for (int md = 0; md < 3; md++) begin
      load(6'b01_01_01, md);
      repeat (6) step(1, 1);
    end

    // 4: prefix overlap
    load(6'b10_01_01, 0);
    step(1, 1); step(1, 1); step(1, 1); step(1, 2);

    // 5: load coincident with final symbol, then reset mid-sequence
    load(6'b11_10_01, 0);
    step(1, 1); step(1, 2); step(1, 3, 1'b1, 6'b11_10_01, 0);
    step(1, 3); step(1, 1); step(1, 2); step(1, 3);
    step(1, 1); step(1, 2); step(0, 0, .rst(1)); step(1, 3);
    load(6'b11_10_01, 0);
    step(1, 1); step(1, 2); step(0, 0, .rst(1)); step(1, 3);

    // 6: counter saturation at CNT_W=2, then cnt_clr against a match, reserved mode
    load(6'b01_01_01, 0);
    repeat (7) step(1, 1);
    step(1, 1, .clr(1));
    step(1, 1); step(0, 0);
    load(6'b01_01_01, 3);
    repeat (5) step(1, 1);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      int r, pat, s;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        step(0, 0, .rst(1));
      end else if (r < 6) begin
        pat = 0;
        for (int k = 0; k < DEPTH; k++)
          pat |= ($urandom_range(0, 9) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 1)) << (k*SYM_W);
        step(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1, pat, $urandom_range(0, 3));
      end else begin
        s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1);
        step(1'($urandom_range(0, 3) != 0), s, .clr(r < 9));
      end
    end

    @(negedge CLK);
    #1;
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
